// File: rtl/approx_eval_pkg.sv
// ---------------------------------------------------------------------------
// approx_eval_pkg
//   Shared types and sizing helpers for the approximate-adder evaluation
//   harness.
//   - state_e : sweep controller states (IDLE / SWEEP / DONE)
//   - vec_w() : width of one stimulus vector (both operands side by side)
//   - cnt_w() : width of a counter that can reach NVEC
//   - nvec()  : number of operand combinations in one exhaustive sweep
// ---------------------------------------------------------------------------
package approx_eval_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int vec_w(input int in_w);
      return 2 * in_w;
   endfunction

   function automatic int cnt_w(input int in_w);
      return 2 * in_w + 1;
   endfunction

   function automatic int nvec(input int in_w);
      return 1 << (2 * in_w);
   endfunction

endpackage

// File: rtl/approx_abs_err.sv
// ---------------------------------------------------------------------------
// approx_abs_err
//   Combinational exact-sum and absolute-difference unit.
//   Ports:
//     a, b        in  IN_W   operands
//     approx_sum  in  OUT_W  sum reported by the approximate adder
//     err         out OUT_W  |approx_sum - (a + b)|
//   Both the exact sum and approx_sum are below 2^OUT_W, so the difference
//   is formed at OUT_W+1 bits and the truncation back to OUT_W is lossless.
//   OUT_W is expected to be at least IN_W+1 so the exact sum fits.
// ---------------------------------------------------------------------------
module approx_abs_err #(
   parameter int IN_W  = 2,
   parameter int OUT_W = IN_W + 1
) (
   input  logic [IN_W-1:0]  a,
   input  logic [IN_W-1:0]  b,
   input  logic [OUT_W-1:0] approx_sum,
   output logic [OUT_W-1:0] err
);

   logic [OUT_W:0] exact;
   logic [OUT_W:0] appr;

   always_comb begin
      exact = (OUT_W+1)'(a) + (OUT_W+1)'(b);
      appr  = {1'b0, approx_sum};
      err   = OUT_W'((appr >= exact) ? (appr - exact) : (exact - appr));
   end

endmodule

// File: rtl/approx_adder_error_sweeper.sv
// ---------------------------------------------------------------------------
// approx_adder_error_sweeper
//   Exhaustively drives every operand pair into an approximate adder and
//   collects worst-case absolute error, violation count and pass/fail
//   against the error threshold ET.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        begin a sweep (honoured only in IDLE or DONE)
//     stim_vec     adder inputs: a = [IN_W-1:0], b = [2*IN_W-1:IN_W]
//     approx_sum   adder outputs, combinational function of stim_vec
//     busy         sweep in progress
//     done         results valid
//     pass         max_err <= ET, only driven high while done
//     max_err      worst absolute error seen
//     err_count    vectors whose error exceeds ET
//     worst_vec    first vector that reached max_err
//     err_sum      (APPROX_ERR_SUM_EN only) sum of all errors, for MAE
//   Build option: define APPROX_ERR_SUM_EN to add the err_sum accumulator.
// ---------------------------------------------------------------------------
module approx_adder_error_sweeper
   import approx_eval_pkg::*;
#(
   parameter int IN_W  = 2,
   parameter int OUT_W = IN_W + 1,
   parameter int ET    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic [2*IN_W-1:0]   stim_vec,
   input  logic [OUT_W-1:0]    approx_sum,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [OUT_W-1:0]    max_err,
   output logic [2*IN_W:0]     err_count,
   output logic [2*IN_W-1:0]   worst_vec
`ifdef APPROX_ERR_SUM_EN
   ,
   output logic [OUT_W+2*IN_W-1:0] err_sum
`endif
);

   localparam int VEC_W = vec_w(IN_W);
   localparam int CNT_W = cnt_w(IN_W);
   localparam int NVEC  = nvec(IN_W);
   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NVEC - 1);
   // A threshold that does not fit in OUT_W bits can never be exceeded.
   localparam bit               ET_FITS  = (ET < (1 << OUT_W));
   localparam logic [OUT_W-1:0] ET_V     = OUT_W'(ET);

   state_e             state_q, state_d;
   logic [VEC_W-1:0]   stim_q;
   logic [OUT_W-1:0]   max_err_q;
   logic [CNT_W-1:0]   err_count_q;
   logic [VEC_W-1:0]   worst_q;
   logic [OUT_W-1:0]   err;
   logic               viol;
   logic               accept;

   approx_abs_err #(.IN_W(IN_W), .OUT_W(OUT_W)) u_abs_err (
      .a          (stim_q[IN_W-1:0]),
      .b          (stim_q[2*IN_W-1:IN_W]),
      .approx_sum (approx_sum),
      .err        (err)
   );

   assign viol   = ET_FITS && (err > ET_V);
   assign accept = start && (state_q != SWEEP);

   // ---- controller ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = SWEEP;
         // The last vector is evaluated in this cycle; stim wraps to 0 and
         // the sweep ends without re-evaluating vector 0.
         SWEEP:      if (stim_q == LAST_VEC) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // ---- statistics ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim_q      <= '0;
         max_err_q   <= '0;
         err_count_q <= '0;
         worst_q     <= '0;
      end else if (accept) begin
         stim_q      <= '0;
         max_err_q   <= '0;
         err_count_q <= '0;
         worst_q     <= '0;
      end else if (state_q == SWEEP) begin
         // Strict compare: ties keep the earliest vector.
         if (err > max_err_q) begin
            max_err_q <= err;
            worst_q   <= stim_q;
         end
         if (viol) err_count_q <= err_count_q + CNT_W'(1);
         stim_q <= stim_q + VEC_W'(1);
      end
   end

`ifdef APPROX_ERR_SUM_EN
   localparam int SUM_W = OUT_W + 2 * IN_W;
   logic [SUM_W-1:0] err_sum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  err_sum_q <= '0;
      else if (accept)             err_sum_q <= '0;
      else if (state_q == SWEEP)   err_sum_q <= err_sum_q + SUM_W'(err);
   end

   assign err_sum = err_sum_q;
`endif

   assign stim_vec  = stim_q;
   assign busy      = (state_q == SWEEP);
   assign done      = (state_q == DONE);
   assign pass      = done && (max_err_q <= ET_V || !ET_FITS);
   assign max_err   = max_err_q;
   assign err_count = err_count_q;
   assign worst_vec = worst_q;

endmodule
